// File: rtl/rx_dco_ctrl_pkg.sv
// rx_dco_ctrl_pkg: shared types, default loop constants and the PD error decode for the RX DCO controller.
// Latency: none (types, constants and a pure function).
// Backpressure: none.
package rx_dco_ctrl_pkg;

  // DCO code format shared with the PWL period lookup and clock timebase.
  localparam int DCO_CODE_WIDTH = 14;
  typedef logic [DCO_CODE_WIDTH-1:0] DCO_CODE_FORMAT;

  // Loop integrator format.
  localparam int RX_DCO_INT_WIDTH = 24;
  localparam int RX_DCO_INT_FRAC  = 8;
  typedef logic signed [RX_DCO_INT_WIDTH-1:0] RX_DCO_INT_FORMAT;

  // Default gain schedule and lock detection constants.
  localparam int RX_DCO_KP_LOG2     = 2;
  localparam int RX_DCO_KI_LOG2     = 0;
  localparam int RX_DCO_ACQ_SHIFT   = 2;
  localparam int RX_DCO_ACQ_SAMPLES = 256;
  localparam int RX_DCO_LOCK_THRESH = 64;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ACQUIRE = 2'd1,
    ST_TRACK   = 2'd2
  } RX_DCO_CTRL_STATE;

  // Bang-bang vote to signed error: both or neither vote is a neutral sample.
  function automatic logic signed [1:0] pd_error(input logic up, input logic dn);
    logic signed [1:0] err;
    err = 2'sd0;
    if (up && !dn) begin
      err = 2'sd1;
    end else if (dn && !up) begin
      err = -2'sd1;
    end
    return err;
  endfunction

endpackage

// File: rtl/rx_dco_ctrl_sat_add.sv
// rx_dco_ctrl_sat_add: signed a+b clamped to [lo_i, hi_i], result truncated to OUT_W bits, with clamp flag.
// Latency: combinational.
// Backpressure: none.
// Ports: a_i/b_i operands, lo_i/hi_i clamp bounds (all W-bit signed), sum_o clamped result, clamp_o set when clamped.
module rx_dco_ctrl_sat_add #(
  parameter int W     = 16,
  parameter int OUT_W = W
) (
  input  logic signed [W-1:0]     a_i,
  input  logic signed [W-1:0]     b_i,
  input  logic signed [W-1:0]     lo_i,
  input  logic signed [W-1:0]     hi_i,
  output logic signed [OUT_W-1:0] sum_o,
  output logic                    clamp_o
);

  // One guard bit so the raw sum never wraps before it is compared to the bounds.
  logic signed [W:0] sum_x;
  logic signed [W:0] lo_x;
  logic signed [W:0] hi_x;

  always_comb begin
    sum_x   = {a_i[W-1], a_i} + {b_i[W-1], b_i};
    lo_x    = {lo_i[W-1], lo_i};
    hi_x    = {hi_i[W-1], hi_i};
    sum_o   = sum_x[OUT_W-1:0];
    clamp_o = 1'b0;
    if (sum_x < lo_x) begin
      sum_o   = lo_x[OUT_W-1:0];
      clamp_o = 1'b1;
    end else if (sum_x > hi_x) begin
      sum_o   = hi_x[OUT_W-1:0];
      clamp_o = 1'b1;
    end
  end

endmodule

// File: rtl/rx_dco_ctrl.sv
// rx_dco_ctrl: bang-bang PI loop (ACQUIRE then TRACK gains) producing the RX DCO code and lock indication.
// Latency: a PD sample reaches code_out one cycle after the first cke strictly after the sample cycle.
// Backpressure: none; PD samples are accepted every cycle, a newer sample overwrites the pending error.
// Ports: clk, rst_n (async active-low), en, cke (RX edge strobe), pd_valid/pd_up/pd_dn (PD votes),
//        code_out (unsigned DCO code), locked, state (0 IDLE, 1 ACQUIRE, 2 TRACK), sat (sticky clamp flag).
// Optional: define RX_DCO_CTRL_OVERRIDE_EN to add ovr_en/ovr_code, which load a fixed code at each cke
//           while freezing the loop and holding locked low.
module rx_dco_ctrl
  import rx_dco_ctrl_pkg::*;
#(
  parameter int          CODE_WIDTH  = DCO_CODE_WIDTH,
  parameter int unsigned INIT_CODE   = 1 << (CODE_WIDTH - 1),
  parameter int          INT_WIDTH   = RX_DCO_INT_WIDTH,
  parameter int          INT_FRAC    = RX_DCO_INT_FRAC,
  parameter int          KP_LOG2     = RX_DCO_KP_LOG2,
  parameter int          KI_LOG2     = RX_DCO_KI_LOG2,
  parameter int          ACQ_SHIFT   = RX_DCO_ACQ_SHIFT,
  parameter int          ACQ_SAMPLES = RX_DCO_ACQ_SAMPLES,
  parameter int          LOCK_THRESH = RX_DCO_LOCK_THRESH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic                  cke,
  input  logic                  pd_valid,
  input  logic                  pd_up,
  input  logic                  pd_dn,
`ifdef RX_DCO_CTRL_OVERRIDE_EN
  input  logic                  ovr_en,
  input  logic [CODE_WIDTH-1:0] ovr_code,
`endif
  output logic [CODE_WIDTH-1:0] code_out,
  output logic                  locked,
  output logic [1:0]            state,
  output logic                  sat
);

  // Code sum width: integer part of the integrator or the code, whichever is wider, plus headroom.
  localparam int SUM_W = ((INT_WIDTH - INT_FRAC) > CODE_WIDTH ? (INT_WIDTH - INT_FRAC) : CODE_WIDTH) + 3;
  localparam int CNT_W = $clog2(ACQ_SAMPLES + 1);
  localparam int LCK_W = $clog2(LOCK_THRESH + 1);

  localparam logic [CNT_W-1:0]          ACQ_DONE  = CNT_W'(ACQ_SAMPLES);
  localparam logic [LCK_W-1:0]          LOCK_FULL = LCK_W'(LOCK_THRESH);
  localparam logic [CODE_WIDTH-1:0]     INIT_C    = CODE_WIDTH'(INIT_CODE);
  localparam logic signed [SUM_W-1:0]   INIT_S    = SUM_W'(INIT_CODE);
  localparam logic signed [SUM_W-1:0]   CODE_LO   = '0;
  localparam logic signed [SUM_W-1:0]   CODE_HI   = SUM_W'((64'd1 << CODE_WIDTH) - 64'd1);
  localparam logic signed [INT_WIDTH-1:0] INT_LO  = {1'b1, {(INT_WIDTH-1){1'b0}}};
  localparam logic signed [INT_WIDTH-1:0] INT_HI  = {1'b0, {(INT_WIDTH-1){1'b1}}};

  RX_DCO_CTRL_STATE            state_q, state_d;
  logic signed [INT_WIDTH-1:0] integ_q, integ_d;
  logic signed [1:0]           pend_e_q, pend_e_d;
  logic signed [1:0]           last_e_q, last_e_d;   // last nonzero error, 0 until one is seen
  logic [CNT_W-1:0]            smp_cnt_q, smp_cnt_d;
  logic [LCK_W-1:0]            lock_cnt_q, lock_cnt_d;
  logic [CODE_WIDTH-1:0]       code_q, code_d;
  logic                        locked_q, locked_d;
  logic                        sat_q, sat_d;

  logic signed [1:0]           e;
  logic                        in_acq;
  logic signed [INT_WIDTH-1:0] e_ext, int_step, integ_sum, integ_sh;
  logic signed [SUM_W-1:0]     pend_ext, prop, code_base;
  logic [CODE_WIDTH-1:0]       code_sum;
  logic                        integ_clamp, code_clamp, clamp_evt;

  assign e      = pd_error(pd_up, pd_dn);
  assign in_acq = (state_q == ST_ACQUIRE);

  // Integral step: e <<< ki, with the extra acquisition shift while in ACQUIRE.
  assign e_ext    = {{(INT_WIDTH-2){e[1]}}, e};
  assign int_step = in_acq ? (e_ext <<< (KI_LOG2 + ACQ_SHIFT)) : (e_ext <<< KI_LOG2);

  // Code = INIT_CODE + integer part of integrator + proportional kick from the pending error.
  // The base sum cannot overflow SUM_W; only the final sum against the code range can clamp.
  assign integ_sh  = integ_q >>> INT_FRAC;
  assign pend_ext  = {{(SUM_W-2){pend_e_q[1]}}, pend_e_q};
  assign prop      = in_acq ? (pend_ext <<< (KP_LOG2 + ACQ_SHIFT)) : (pend_ext <<< KP_LOG2);
  assign code_base = INIT_S + SUM_W'(integ_sh);

  rx_dco_ctrl_sat_add #(.W(INT_WIDTH), .OUT_W(INT_WIDTH)) u_integ_add (
    .a_i     (integ_q),
    .b_i     (int_step),
    .lo_i    (INT_LO),
    .hi_i    (INT_HI),
    .sum_o   (integ_sum),
    .clamp_o (integ_clamp)
  );

  rx_dco_ctrl_sat_add #(.W(SUM_W), .OUT_W(CODE_WIDTH)) u_code_add (
    .a_i     (code_base),
    .b_i     (prop),
    .lo_i    (CODE_LO),
    .hi_i    (CODE_HI),
    .sum_o   (code_sum),
    .clamp_o (code_clamp)
  );

  always_comb begin
    state_d    = state_q;
    integ_d    = integ_q;
    pend_e_d   = pend_e_q;
    last_e_d   = last_e_q;
    smp_cnt_d  = smp_cnt_q;
    lock_cnt_d = lock_cnt_q;
    code_d     = code_q;
    locked_d   = locked_q;
    sat_d      = sat_q;
    clamp_evt  = 1'b0;

    if (!en || state_q == ST_IDLE) begin
      // IDLE holds every loop register at its reset value, so entry to ACQUIRE starts clean.
      state_d    = en ? ST_ACQUIRE : ST_IDLE;
      integ_d    = '0;
      pend_e_d   = '0;
      last_e_d   = '0;
      smp_cnt_d  = '0;
      lock_cnt_d = '0;
      code_d     = INIT_C;
      locked_d   = 1'b0;
      sat_d      = 1'b0;
    end else begin
      // cke consumes the registered integrator and pending error; a coincident sample
      // overwrites pend_e below and is therefore applied at the following cke.
      if (cke) begin
        code_d    = code_sum;
        pend_e_d  = '0;
        clamp_evt = code_clamp;
      end
      if (pd_valid) begin
        integ_d   = integ_sum;
        pend_e_d  = e;
        clamp_evt = clamp_evt | integ_clamp;
        if (e != 2'sd0) begin
          last_e_d = e;
        end
        if (in_acq) begin
          if (smp_cnt_q != ACQ_DONE) begin
            smp_cnt_d = smp_cnt_q + CNT_W'(1);
          end
          if (smp_cnt_d == ACQ_DONE) begin
            state_d = ST_TRACK;
          end
        end else if (e != 2'sd0 && e == last_e_q) begin
          // Repeated same-direction vote: the loop is still slewing.
          lock_cnt_d = '0;
        end else if (lock_cnt_q != LOCK_FULL) begin
          lock_cnt_d = lock_cnt_q + LCK_W'(1);
        end
      end
      if (clamp_evt) begin
        sat_d      = 1'b1;
        lock_cnt_d = '0;
      end
      locked_d = (state_q == ST_TRACK) && (lock_cnt_d == LOCK_FULL);
`ifdef RX_DCO_CTRL_OVERRIDE_EN
      // Override: loop frozen, samples dropped, code forced at each cke, lock held low.
      if (ovr_en) begin
        state_d    = state_q;
        integ_d    = integ_q;
        pend_e_d   = pend_e_q;
        last_e_d   = last_e_q;
        smp_cnt_d  = smp_cnt_q;
        lock_cnt_d = lock_cnt_q;
        sat_d      = sat_q;
        code_d     = cke ? ovr_code : code_q;
        locked_d   = 1'b0;
      end
`endif
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      integ_q    <= '0;
      pend_e_q   <= '0;
      last_e_q   <= '0;
      smp_cnt_q  <= '0;
      lock_cnt_q <= '0;
      code_q     <= INIT_C;
      locked_q   <= 1'b0;
      sat_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      integ_q    <= integ_d;
      pend_e_q   <= pend_e_d;
      last_e_q   <= last_e_d;
      smp_cnt_q  <= smp_cnt_d;
      lock_cnt_q <= lock_cnt_d;
      code_q     <= code_d;
      locked_q   <= locked_d;
      sat_q      <= sat_d;
    end
  end

  assign code_out = code_q;
  assign locked   = locked_q;
  assign state    = state_q;
  assign sat      = sat_q;

endmodule
